// File: rtl/eth_sw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_sw_pkg
// Description : Shared types and constants for the ethernet_switch egress path.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_sw_pkg;

    localparam int ETH_DATA_W    = 32;
    localparam int ETH_MAX_WORDS = 381;

    typedef enum logic [2:0] {
        IDLE,
        GRANT_A,
        GRANT_B,
        DROP_A,
        DROP_B
    } arb_state_e;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_e;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  err;
    } eth_word_t;

endpackage
`default_nettype wire

// File: rtl/eth_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : eth_out_stage
// Description : One-entry egress register with valid/ready. Accepting a new
//               word while the held word drains keeps one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_out_stage
    import eth_sw_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_valid,
    input  eth_word_t i_word,
    output logic      o_ready,
    output logic      o_valid,
    output eth_word_t o_word,
    input  logic      i_ready
);

    logic      r_valid;
    eth_word_t r_word;

    // The register can take a word when empty or when its word leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_word  = r_word;

    // Load on an accepted word; otherwise empty out on an egress handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_word  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_egress_arbiter
// Description : Frame-granular round-robin 2:1 arbiter for one switch egress
//               port, with maximum-length truncation, malformed-word drop and
//               saturating per-input frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_egress_arbiter
    import eth_sw_pkg::*;
#(
    parameter int DATA_W    = ETH_DATA_W,
    parameter int MAX_WORDS = ETH_MAX_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_a,
    input  logic              in_sop_a,
    input  logic              in_eop_a,
    input  logic [DATA_W-1:0] in_data_a,
    output logic              in_ready_a,
    input  logic              in_valid_b,
    input  logic              in_sop_b,
    input  logic              in_eop_b,
    input  logic [DATA_W-1:0] in_data_b,
    output logic              in_ready_b,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              err_sop,
    output logic [CNT_W-1:0]  frames_a,
    output logic [CNT_W-1:0]  frames_b
);

    localparam int c_wcnt_w = $clog2(MAX_WORDS + 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    port_e               r_last_grant;
    port_e               w_last_nxt;
    logic [c_wcnt_w-1:0] r_wcnt;
    logic [c_wcnt_w-1:0] w_wcnt_nxt;
    logic [c_wcnt_w-1:0] w_wcnt_inc;
    logic [CNT_W-1:0]    r_frames_a;
    logic [CNT_W-1:0]    r_frames_b;
    logic                r_err_sop;

    logic                w_sop_a;
    logic                w_sop_b;
    logic                w_sel_b;
    logic                w_g_valid;
    logic                w_g_eop;
    logic [DATA_W-1:0]   w_g_data;
    logic                w_ready_a;
    logic                w_ready_b;
    logic                w_drop_err;
    logic                w_inc_a;
    logic                w_inc_b;
    logic                w_push;
    eth_word_t           w_word;
    logic                w_stage_ready;
    eth_word_t           w_out_word;

    assign w_sop_a    = in_valid_a && in_sop_a;
    assign w_sop_b    = in_valid_b && in_sop_b;
    assign w_sel_b    = (r_state == GRANT_B) || (r_state == DROP_B);
    assign w_g_valid  = w_sel_b ? in_valid_b : in_valid_a;
    assign w_g_eop    = w_sel_b ? in_eop_b   : in_eop_a;
    assign w_g_data   = w_sel_b ? in_data_b  : in_data_a;
    assign w_wcnt_inc = r_wcnt + 1'b1;

    // Next-state, ready, egress word and counter strobes for the arbiter.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_wcnt_nxt  = r_wcnt;
        w_ready_a   = 1'b0;
        w_ready_b   = 1'b0;
        w_drop_err  = 1'b0;
        w_inc_a     = 1'b0;
        w_inc_b     = 1'b0;
        w_push      = 1'b0;
        w_word      = '0;
        case (r_state)
            IDLE: begin
                // Words without SOP are swallowed here; SOP words wait for the grant.
                w_ready_a  = in_valid_a && !in_sop_a;
                w_ready_b  = in_valid_b && !in_sop_b;
                w_drop_err = w_ready_a || w_ready_b;
                if (w_sop_a && (!w_sop_b || r_last_grant == PORT_B)) begin
                    w_state_nxt = GRANT_A;
                end else if (w_sop_b) begin
                    w_state_nxt = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (w_sel_b) w_ready_b = w_stage_ready;
                else         w_ready_a = w_stage_ready;
                if (w_g_valid && w_stage_ready) begin
                    w_push      = 1'b1;
                    w_word.data = w_g_data;
                    w_word.sop  = (r_wcnt == '0);
                    w_wcnt_nxt  = w_wcnt_inc;
                    if (w_g_eop || w_wcnt_inc == c_wcnt_w'(MAX_WORDS)) begin
                        // Frame closes here, either normally or cut at the length limit.
                        w_word.eop = 1'b1;
                        w_word.err = !w_g_eop;
                        w_wcnt_nxt = '0;
                        if (w_sel_b) w_inc_b = 1'b1;
                        else         w_inc_a = 1'b1;
                        if (w_g_eop) begin
                            w_state_nxt = IDLE;
                            w_last_nxt  = w_sel_b ? PORT_B : PORT_A;
                        end else begin
                            w_state_nxt = w_sel_b ? DROP_B : DROP_A;
                        end
                    end
                end
            end
            DROP_A, DROP_B: begin
                if (w_sel_b) w_ready_b = 1'b1;
                else         w_ready_a = 1'b1;
                if (w_g_valid && w_g_eop) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = w_sel_b ? PORT_B : PORT_A;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Arbiter state, word counter, error pulse and saturating frame counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_B;
            r_wcnt       <= '0;
            r_frames_a   <= '0;
            r_frames_b   <= '0;
            r_err_sop    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_wcnt       <= w_wcnt_nxt;
            r_err_sop    <= w_drop_err;
            if (w_inc_a && r_frames_a != '1) r_frames_a <= r_frames_a + 1'b1;
            if (w_inc_b && r_frames_b != '1) r_frames_b <= r_frames_b + 1'b1;
        end
    end

    eth_out_stage u_out_stage (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_push),
        .i_word  (w_word),
        .o_ready (w_stage_ready),
        .o_valid (out_valid),
        .o_word  (w_out_word),
        .i_ready (out_ready)
    );

    // Ready is held low while reset is asserted so no word appears accepted.
    assign in_ready_a = reset && w_ready_a;
    assign in_ready_b = reset && w_ready_b;
    assign out_data   = w_out_word.data;
    assign out_sop    = w_out_word.sop;
    assign out_eop    = w_out_word.eop;
    assign out_err    = w_out_word.err;
    assign err_sop    = r_err_sop;
    assign frames_a   = r_frames_a;
    assign frames_b   = r_frames_b;

endmodule
`default_nettype wire

// File: tb/tb_eth_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_egress_arbiter
// Description : Directed self-checking bench for eth_egress_arbiter
//               (frame length limit reduced to 8 words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_egress_arbiter;

    localparam int DW = 32;
    localparam int MW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid_a, in_sop_a, in_eop_a, in_ready_a;
    logic [DW-1:0] in_data_a;
    logic          in_valid_b, in_sop_b, in_eop_b, in_ready_b;
    logic [DW-1:0] in_data_b;
    logic          out_valid, out_sop, out_eop, out_err, out_ready, err_sop;
    logic [DW-1:0] out_data;
    logic [CW-1:0] frames_a, frames_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [34:0] cap_q[$];
    int          cap_cyc[$];
    logic [34:0] exp_q[$];

    eth_egress_arbiter #(.DATA_W(DW), .MAX_WORDS(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid_a(in_valid_a), .in_sop_a(in_sop_a), .in_eop_a(in_eop_a),
        .in_data_a(in_data_a), .in_ready_a(in_ready_a),
        .in_valid_b(in_valid_b), .in_sop_b(in_sop_b), .in_eop_b(in_eop_b),
        .in_data_b(in_data_b), .in_ready_b(in_ready_b),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_err(out_err), .out_data(out_data), .out_ready(out_ready),
        .err_sop(err_sop), .frames_a(frames_a), .frames_b(frames_b)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every egress word that will be consumed at the next edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            cap_q.push_back({out_err, out_eop, out_sop, out_data});
            cap_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] mk(input logic [31:0] d, input bit s, input bit e, input bit r);
        return {r, e, s, d};
    endfunction

    function automatic int cyc_at(input int i);
        if (i < cap_cyc.size()) return cap_cyc[i];
        return -1000;
    endfunction

    // Hand-derived egress image of an n-word frame: word k is base*k.
    task automatic exp_frame(input int n, input logic [31:0] base);
        for (int i = 0; i < n && i < MW; i++) begin
            exp_q.push_back(mk(base * 32'(i + 1), i == 0,
                               (i == n - 1) || (i == MW - 1),
                               (i == MW - 1) && (n > MW)));
        end
    endtask

    task automatic compare_caps(input string tag);
        check({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(cap_q[i]), 64'(exp_q[i]));
    endtask

    task automatic clear_caps();
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic drive_word(input bit port, input bit v, input bit s, input bit e,
                              input logic [31:0] d);
        if (!port) begin
            in_valid_a = v; in_sop_a = s; in_eop_a = e; in_data_a = d;
        end else begin
            in_valid_b = v; in_sop_b = s; in_eop_b = e; in_data_b = d;
        end
    endtask

    // Wait (bounded) until the presented word is accepted; returns just after that edge.
    task automatic wait_accept(input bit port, output int stalls);
        stalls = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if ((port ? in_ready_b : in_ready_a) === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input bit port, input int n, input logic [31:0] base,
                              output int start, output int stalls);
        int s;
        stalls = 0;
        start  = cyc;
        for (int i = 0; i < n; i++) begin
            drive_word(port, 1'b1, i == 0, i == n - 1, base * 32'(i + 1));
            wait_accept(port, s);
            stalls += s;
        end
        drive_word(port, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive_word(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive_word(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa, sb, xa, xb, st, stl;
        apply_reset();

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_markers", 64'({out_sop, out_eop, out_err, err_sop}), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_ready", 64'({in_ready_a, in_ready_b}), 64'd0);
        check("rst_frames", 64'({frames_a, frames_b}), 64'd0);
        @(posedge clk); #1;

        // Single 4-word frame from A.
        send_frame(1'b0, 4, 32'h11111111, st, stl);
        repeat (3) @(posedge clk); #1;
        exp_frame(4, 32'h11111111);
        compare_caps("single");
        check("single_latency", 64'(cyc_at(0) - st), 64'd2);
        check("single_contig", 64'(cyc_at(3) - cyc_at(0)), 64'd3);
        check("single_frames_a", 64'(frames_a), 64'd1);
        clear_caps();

        // Tie after reset, two rounds: A, B, A, B.
        apply_reset();
        clear_caps();
        repeat (2) begin
            fork
                send_frame(1'b0, 2, 32'h0A000001, sa, xa);
                send_frame(1'b1, 2, 32'h0B000001, sb, xb);
            join
            exp_frame(2, 32'h0A000001);
            exp_frame(2, 32'h0B000001);
        end
        repeat (3) @(posedge clk); #1;
        compare_caps("tie");
        check("tie_bubble_ab", 64'(cyc_at(2) - cyc_at(1)), 64'd2);
        check("tie_bubble_ba", 64'(cyc_at(4) - cyc_at(3)), 64'd2);
        check("tie_frames_a", 64'(frames_a), 64'd2);
        check("tie_frames_b", 64'(frames_b), 64'd2);
        clear_caps();

        // Backpressure on word 2 of a 5-word A frame.
        fork
            send_frame(1'b0, 5, 32'h01000000, sa, xa);
            begin
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1 && out_data === 32'h01000000) break;
                end
                @(posedge clk); #1 out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_hold_data%0d", k), 64'(out_data), 64'h02000000);
                    check($sformatf("bp_hold_valid%0d", k), 64'(out_valid), 64'd1);
                    check($sformatf("bp_ready_a%0d", k), 64'(in_ready_a), 64'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk); #1;
        exp_frame(5, 32'h01000000);
        compare_caps("bp");
        check("bp_frames_a", 64'(frames_a), 64'd3);
        clear_caps();

        // Truncation of a 12-word A frame with a B frame waiting behind it.
        fork
            send_frame(1'b0, 12, 32'h00000101, sa, xa);
            begin
                repeat (3) @(posedge clk); #1;
                send_frame(1'b1, 2, 32'h00B0B000, sb, xb);
            end
        join
        repeat (3) @(posedge clk); #1;
        exp_frame(12, 32'h00000101);
        exp_frame(2, 32'h00B0B000);
        compare_caps("trunc");
        check("trunc_a_stalls", 64'(xa), 64'd1);
        check("trunc_b_gap", 64'(cyc_at(8) - cyc_at(7)), 64'd6);
        check("trunc_frames_a", 64'(frames_a), 64'd4);
        check("trunc_frames_b", 64'(frames_b), 64'd3);
        clear_caps();

        // Word without SOP from B in IDLE.
        drive_word(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        check("perr_ready_b", 64'(in_ready_b), 64'd1);
        check("perr_pulse_before", 64'(err_sop), 64'd0);
        @(posedge clk); #1;
        drive_word(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("perr_pulse", 64'(err_sop), 64'd1);
        check("perr_no_egress", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("perr_pulse_end", 64'(err_sop), 64'd0);
        check("perr_caps", 64'(cap_q.size()), 64'd0);
        check("perr_frames_b", 64'(frames_b), 64'd3);
        @(posedge clk); #1;

        // Reset while word 3 of an A frame is presented.
        drive_word(1'b0, 1'b1, 1'b1, 1'b0, 32'h00C00001);
        wait_accept(1'b0, stl);
        drive_word(1'b0, 1'b1, 1'b0, 1'b0, 32'h00C00002);
        wait_accept(1'b0, stl);
        drive_word(1'b0, 1'b1, 1'b0, 1'b0, 32'h00C00003);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        drive_word(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("mrst_out_valid", 64'(out_valid), 64'd0);
        check("mrst_markers", 64'({out_sop, out_eop, out_err, err_sop}), 64'd0);
        check("mrst_frames", 64'({frames_a, frames_b}), 64'd0);
        check("mrst_ready_a", 64'(in_ready_a), 64'd0);
        clear_caps();
        @(posedge clk); #1;
        send_frame(1'b1, 2, 32'h0E000001, st, stl);
        repeat (3) @(posedge clk); #1;
        exp_frame(2, 32'h0E000001);
        compare_caps("mrst_b");
        check("mrst_b_latency", 64'(cyc_at(0) - st), 64'd2);
        check("mrst_frames_b", 64'(frames_b), 64'd1);
        check("mrst_frames_a", 64'(frames_a), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
